// File: rtl/instr_encoder.sv
// Encodes RV32I field-level commands into instruction words and writes them to instruction memory (optional JAL: ENC_JAL_EN).
// Latency: a beat accepted at edge N drives mem_we/mem_addr/mem_wdata during cycle N+1 for one cycle.
// Backpressure: in_ready is high only in RUN with count below DEPTH; one beat per cycle, no bubbles.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_class,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [20:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  err_nxt;
    logic                  we_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [31:0]           wdata_nxt;
    logic                  accept;
    logic                  legal;
    logic                  imm_misalign;
    logic [31:0]           word;

    assign in_ready = (state == RUN) && (count < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        word         = '0;
        legal        = 1'b1;
        imm_misalign = 1'b0;
        case (in_class)
            3'd0: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            3'd2: word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            3'd3: word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            3'd4: begin
                // Branch offsets are halfword-aligned; bit 0 is dropped but flagged.
                word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
                imm_misalign = in_imm[0];
            end
`ifdef ENC_JAL_EN
            3'd5: begin
                word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                        in_rd, 7'b1101111};
                imm_misalign = in_imm[0];
            end
`endif
            default: legal = 1'b0;
        endcase
    end

`ifndef ENC_JAL_EN
    logic unused_imm;
    assign unused_imm = ^in_imm[20:13];
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        err_nxt   = err;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (legal) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = count[ADDR_WIDTH-1:0];
                        wdata_nxt = word;
                        count_nxt = count + (ADDR_WIDTH+1)'(1);
                        if (imm_misalign) err_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    if (in_last) begin
                        state_nxt = DONE;
                    end else if (legal && (count_nxt == DEPTH_C)) begin
                        // Ran out of room before the program said it was finished.
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            count     <= count_nxt;
            err       <= err_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4 so the full condition is reachable).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [20:0] in_imm;
    logic        in_last;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err;
    logic [8:0]  count;

    int checks = 0;
    int passed = 0;

    instr_encoder #(.ADDR_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic set_beat(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [20:0] imm, input logic last);
        in_valid = 1'b1; in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
        checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else passed++;
        checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, err}); else passed++;
        checks++; if (count !== 9'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        checks++; if ({mem_addr, mem_wdata} !== 40'd0) $display("FAIL reset_mem_bus got %h want 0", {mem_addr, mem_wdata}); else passed++;
        @(negedge clk); rst = 1'b0;
    endtask

    // start and a valid beat together in IDLE: nothing accepted until RUN.
    task automatic test_r_type();
        @(negedge clk);
        start = 1'b1;
        set_beat(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (mem_we !== 1'b0) $display("FAIL start_same_cycle_we got %b want 0", mem_we); else passed++;
        checks++; if ({busy, count} !== {1'b1, 9'd0}) $display("FAIL start_same_cycle_busy_count got %b/%0d want 1/0", busy, count); else passed++;
        @(posedge clk); #1;
        idle_in();
        checks++; if ({mem_we, mem_addr} !== {1'b1, 8'd0}) $display("FAIL add_we_addr got %b/%0d want 1/0", mem_we, mem_addr); else passed++;
        checks++; if (mem_wdata !== 32'h002081B3) $display("FAIL add_wdata got %h want 002081b3", mem_wdata); else passed++;
        checks++; if ({count, done} !== {9'd1, 1'b1}) $display("FAIL add_count_done got %0d/%b want 1/1", count, done); else passed++;
    endtask

    task automatic test_back_to_back();
        do_start();
        checks++; if ({count, busy, done} !== {9'd0, 1'b1, 1'b0}) $display("FAIL restart got %0d/%b/%b want 0/1/0", count, busy, done); else passed++;
        set_beat(3'd2, 5'd5, 5'd0, 5'd0, 3'd7, 7'd0, 21'd8, 1'b0);
        @(posedge clk); #1;
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd0, 32'h00802283}) $display("FAIL lw_write got %b/%0d/%h want 1/0/00802283", mem_we, mem_addr, mem_wdata); else passed++;
        set_beat(3'd3, 5'd0, 5'd2, 5'd5, 3'd0, 7'd0, 21'd4, 1'b1);
        @(posedge clk); #1;
        idle_in();
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd1, 32'h00512223}) $display("FAIL sw_write got %b/%0d/%h want 1/1/00512223", mem_we, mem_addr, mem_wdata); else passed++;
        checks++; if ({done, busy, count} !== {1'b1, 1'b0, 9'd2}) $display("FAIL b2b_end got %b/%b/%0d want 1/0/2", done, busy, count); else passed++;
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b0) $display("FAIL we_single_pulse got %b want 0", mem_we); else passed++;
    endtask

    task automatic test_branch();
        do_start();
        set_beat(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'h1FFFF8, 1'b0);
        @(posedge clk); #1;
        checks++; if ({mem_wdata, err} !== {32'hFE208CE3, 1'b0}) $display("FAIL beq_m8 got %h/%b want fe208ce3/0", mem_wdata, err); else passed++;
        set_beat(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'h1FFFF9, 1'b1);
        @(posedge clk); #1;
        idle_in();
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd1, 32'hFE208CE3}) $display("FAIL beq_m7_write got %b/%0d/%h want 1/1/fe208ce3", mem_we, mem_addr, mem_wdata); else passed++;
        checks++; if ({err, done} !== 2'b11) $display("FAIL beq_m7_err got %b want 11", {err, done}); else passed++;
    endtask

    task automatic test_illegal();
        do_start();
        checks++; if (err !== 1'b0) $display("FAIL start_clears_err got %b want 0", err); else passed++;
        set_beat(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 1'b0);
        @(posedge clk); #1;
        set_beat(3'd6, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 1'b0);
        @(posedge clk); #1;
        checks++; if ({mem_we, count, err} !== {1'b0, 9'd1, 1'b1}) $display("FAIL illegal got we=%b cnt=%0d err=%b want 0/1/1", mem_we, count, err); else passed++;
        set_beat(3'd2, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 21'd8, 1'b1);
        @(posedge clk); #1;
        idle_in();
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd1, 32'h00802283}) $display("FAIL after_illegal got %b/%0d/%h want 1/1/00802283", mem_we, mem_addr, mem_wdata); else passed++;
        checks++; if ({count, done} !== {9'd2, 1'b1}) $display("FAIL after_illegal_state got %0d/%b want 2/1", count, done); else passed++;
    endtask

    task automatic test_full();
        logic [31:0] exp;
        do_start();
        for (int i = 0; i < 4; i++) begin
            set_beat(3'd1, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 21'(i), 1'b0);
            @(posedge clk); #1;
            exp = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'(i), exp}) $display("FAIL full_write%0d got %b/%0d/%h want 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, i, exp); else passed++;
        end
        checks++; if ({done, err, in_ready, count} !== {3'b110, 9'd4}) $display("FAIL full_state got done=%b err=%b rdy=%b cnt=%0d want 1/1/0/4", done, err, in_ready, count); else passed++;
        @(posedge clk); #1;
        idle_in();
        checks++; if ({mem_we, count} !== {1'b0, 9'd4}) $display("FAIL fifth_beat got we=%b cnt=%0d want 0/4", mem_we, count); else passed++;
        do_start();
        checks++; if ({err, count, in_ready} !== {1'b0, 9'd0, 1'b1}) $display("FAIL full_restart got err=%b cnt=%0d rdy=%b want 0/0/1", err, count, in_ready); else passed++;
    endtask

    task automatic test_jal();
        set_beat(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd16, 1'b1);
        @(posedge clk); #1;
        idle_in();
`ifdef ENC_JAL_EN
        checks++; if ({mem_we, mem_wdata} !== {1'b1, 32'h010000EF}) $display("FAIL jal_write got %b/%h want 1/010000ef", mem_we, mem_wdata); else passed++;
        checks++; if ({err, done} !== 2'b01) $display("FAIL jal_flags got %b want 01", {err, done}); else passed++;
`else
        checks++; if ({mem_we, count} !== {1'b0, 9'd0}) $display("FAIL jal_disabled_write got we=%b cnt=%0d want 0/0", mem_we, count); else passed++;
        checks++; if ({err, done} !== 2'b11) $display("FAIL jal_disabled_flags got %b want 11", {err, done}); else passed++;
`endif
    endtask

    task automatic test_rst_mid();
        do_start();
        set_beat(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 1'b0);
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b1) $display("FAIL pre_rst_we got %b want 1", mem_we); else passed++;
        rst = 1'b1;
        #1;
        idle_in();
        checks++; if (mem_we !== 1'b0) $display("FAIL rst_async_we got %b want 0", mem_we); else passed++;
        checks++; if ({busy, done, err, in_ready, count} !== {4'b0000, 9'd0}) $display("FAIL rst_async_state got %b/%b/%b/%b/%0d want 0/0/0/0/0", busy, done, err, in_ready, count); else passed++;
        checks++; if ({mem_addr, mem_wdata} !== 40'd0) $display("FAIL rst_async_bus got %h want 0", {mem_addr, mem_wdata}); else passed++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({mem_we, busy} !== 2'b00) $display("FAIL post_rst_idle got %b want 00", {mem_we, busy}); else passed++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_class = 3'd0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
        in_imm = '0; in_last = 1'b0;
        test_reset();
        test_r_type();
        test_back_to_back();
        test_branch();
        test_illegal();
        test_full();
        test_jal();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
